silife_grid: RTL and testbench
==============================

Name: silife_grid

Overview:
- Parametrised successor of the fixed 8x8 Game of Life matrix.
- Holds a WIDTH x HEIGHT cell array and advances one Conway generation (B3/S23) per enabled cycle.
- Supports row-addressed set/clear writes and a row read-back port.
- Adds a saturating generation counter plus stable and extinct status flags for the display/controller layer above it.

Parameters:
- WIDTH, 8, columns per row; bit i of a row is column i; minimum 3.
- HEIGHT, 8, number of rows; minimum 3.
- ROW_BITS, $clog2(HEIGHT), width of the row address.
- GEN_BITS, 16, width of the generation counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears the grid, the counter and the flags.
- enable  input  1  when high and no write is pending, compute one generation this cycle.
- row_select  input  ROW_BITS  row addressed for write and read-back.
- set_cells  input  WIDTH  cells to force alive in the selected row.
- clear_cells  input  WIDTH  cells to force dead in the selected row.
- write_en  input  1  applies set_cells/clear_cells to row_select this cycle.
- cells  output  WIDTH  current contents of row row_select (combinational read of registered state).
- gen_count  output  GEN_BITS  generations computed since reset.
- stable  output  1  last step produced a grid identical to its input.
- extinct  output  1  grid is entirely dead.

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high (already decided).
- Reset values: grid all 0, gen_count=0, stable=0, extinct=1.
- Priority per cycle: reset > write_en > enable.
- Write: row <= (row | set_cells) & ~clear_cells, so clear wins on overlapping bits.
  - No generation step in a write cycle; gen_count and stable are unchanged.
  - extinct is updated from the new grid.
  - row_select >= HEIGHT: the write is ignored and nothing changes.
- Step (enable=1, write_en=0): every cell updates simultaneously from the previous grid.
  - Count live neighbours n over the 8 neighbours.
  - next = (n==3) | (alive & n==2).
- Edges: without the optional feature, out-of-grid neighbours count as dead.
- Step latency: one cycle; the new grid is visible on cells the cycle after the enabling edge.
- Step side effects:
  - gen_count increments by 1 and saturates at all-ones (no wrap).
  - stable <= (next grid == current grid).
  - extinct <= (next grid == 0).
- Idle (enable=0, write_en=0): all state holds.
- Extinct grid with enable=1: keeps stepping; gen_count keeps incrementing; stable=1.
- Read-back: row_select >= HEIGHT returns cells=0.
- Reset asserted mid-run: takes effect at the next edge and overrides any concurrent write or step.
- Implementation shape: neighbour counts are combinational per cell (3-bit count; n>=4 means death); no multi-cycle sweeping.

Optional Feature:
- Macro: SILIFE_WRAP_EN.
- Defined: toroidal topology.
  - Column -1 maps to WIDTH-1 and column WIDTH maps to 0.
  - Row -1 maps to HEIGHT-1 and row HEIGHT maps to 0.
- Undefined: edge neighbours are dead, with no wrap logic synthesised.
- All other behaviour is identical in both builds.

Decomposition:
- Package silife_pkg:
  - Rule constants BIRTH_COUNT=3, SURVIVE_LO=2, SURVIVE_HI=3.
  - Typedef for the 3-bit neighbour count.
- Sub-module silife_cell:
  - Inputs: clk, reset, enable, write/set/clear bits and 8 neighbour bits.
  - Holds one cell register and applies the rule.
  - Instantiated WIDTH x HEIGHT via generate.
- silife_grid owns the neighbour wiring (edge/wrap), write decode, read mux, counter and flags.

Test Plan:
- Blinker: reset, write row 4 set=0x70, then enable 1 cycle -> rows 3,4,5 = 0x20 and gen_count=1; second step -> row 4=0x70, others 0, gen_count=2, stable=0.
- Block: set rows 2,3 = 0x0C, step -> grid unchanged, stable=1, extinct=0.
- Single cell: set row 0 = 0x01, step -> all rows 0, extinct=1; further steps keep extinct=1, stable=1, and gen_count increments.
- Write/step collision: enable=1 and write_en=1 with row 5 set=0x80 -> row 5 = 0x80 with no step applied, gen_count unchanged; set=clear=0xFF -> row 5 = 0x00.
- Edge behaviour: glider moving toward the bottom-right for 32 steps -> with SILIFE_WRAP_EN it reappears at the top-left, 5 live cells, extinct=0; without the macro it degrades into a 2x2 block in the corner, stable=1 by step 32.
- Reset mid-run and saturation:
  - Reset while stepping -> next cycle grid 0, gen_count=0, extinct=1.
  - With GEN_BITS=4, 20 steps -> gen_count=15.

Source files
------------

// File: rtl/silife_pkg.sv
// Purpose: shared rule constants, neighbour-count type and counting helper for the Life grid.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package silife_pkg;

  // Neighbour count. Saturates at 7 rather than wrapping, because 8 neighbours
  // wrapping to 0 would be harmless but confusing in a waveform.
  typedef logic [2:0] nbr_cnt_t;

  // B3/S23
  localparam nbr_cnt_t BIRTH_COUNT = 3'd3;
  localparam nbr_cnt_t SURVIVE_LO  = 3'd2;
  localparam nbr_cnt_t SURVIVE_HI  = 3'd3;

  function automatic nbr_cnt_t count_neighbours(input logic [7:0] nbr);
    nbr_cnt_t cnt;
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      if (nbr[i] && (cnt != 3'd7)) cnt = cnt + 3'd1;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/silife_cell.sv
// Purpose: one Life cell register plus its B3/S23 next-state rule.
// Latency: next state registered on the enabling edge (1 cycle).
// Backpressure: none; accepts a write or a step every cycle.
//
// Ports: clk/reset (sync, active-high); enable = step this cycle; write_en with
// set_bit/clear_bit = direct write (clear wins); neighbours = 8 surrounding cells;
// alive = registered state; next_alive = combinational rule result.
module silife_cell
  import silife_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       write_en,
  input  logic       set_bit,
  input  logic       clear_bit,
  input  logic [7:0] neighbours,
  output logic       alive,
  output logic       next_alive
);

  nbr_cnt_t n;

  assign n = count_neighbours(neighbours);

  assign next_alive = (n == BIRTH_COUNT) |
                      (alive & (n >= SURVIVE_LO) & (n <= SURVIVE_HI));

  always_ff @(posedge clk) begin
    if (reset) begin
      alive <= 1'b0;
    end else if (write_en) begin
      alive <= (alive | set_bit) & ~clear_bit;
    end else if (enable) begin
      alive <= next_alive;
    end
  end

endmodule

// File: rtl/silife_grid.sv
// Purpose: WIDTH x HEIGHT Conway grid with row write/read, generation counter and status flags.
// Latency: a step or write is visible on cells one cycle after the edge that applied it.
// Backpressure: none; write_en takes priority and suppresses the step in the same cycle.
//
// Ports: clk, reset (sync, active-high), enable (step), row_select, set_cells,
// clear_cells, write_en; outputs cells (row read-back, 0 for rows >= HEIGHT),
// gen_count (saturating), stable (last step left grid unchanged), extinct (grid empty).
// Build option: define SILIFE_WRAP_EN for toroidal edges; otherwise edge neighbours are dead.
module silife_grid
  import silife_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int HEIGHT   = 8,
  parameter int ROW_BITS = $clog2(HEIGHT),
  parameter int GEN_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [ROW_BITS-1:0] row_select,
  input  logic [WIDTH-1:0]    set_cells,
  input  logic [WIDTH-1:0]    clear_cells,
  input  logic                write_en,
  output logic [WIDTH-1:0]    cells,
  output logic [GEN_BITS-1:0] gen_count,
  output logic                stable,
  output logic                extinct
);

`ifdef SILIFE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam int NCELLS = WIDTH * HEIGHT;

  // Flat row-major state: cell (r,c) lives at bit r*WIDTH + c.
  logic [NCELLS-1:0] grid_q;
  logic [NCELLS-1:0] next_grid;
  logic [HEIGHT-1:0] row_hit;
  logic              step_en;

  // A write cycle never steps, even if the write targets a non-existent row.
  assign step_en = enable & ~write_en;

  for (genvar r = 0; r < HEIGHT; r++) begin : g_row
    assign row_hit[r] = write_en && (32'(row_select) == r);

    for (genvar c = 0; c < WIDTH; c++) begin : g_col
      localparam int RU = (r == 0)          ? HEIGHT - 1 : r - 1;
      localparam int RD = (r == HEIGHT - 1) ? 0          : r + 1;
      localparam int CL = (c == 0)          ? WIDTH - 1  : c - 1;
      localparam int CR = (c == WIDTH - 1)  ? 0          : c + 1;

      // Without wrap these fold to constant 0 at the edges, so no wrap wiring remains.
      localparam bit UP_OK = WRAP || (r != 0);
      localparam bit DN_OK = WRAP || (r != HEIGHT - 1);
      localparam bit LF_OK = WRAP || (c != 0);
      localparam bit RT_OK = WRAP || (c != WIDTH - 1);

      logic [7:0] nbr;

      assign nbr[0] = (UP_OK && LF_OK) ? grid_q[RU*WIDTH + CL] : 1'b0;
      assign nbr[1] = UP_OK            ? grid_q[RU*WIDTH + c]  : 1'b0;
      assign nbr[2] = (UP_OK && RT_OK) ? grid_q[RU*WIDTH + CR] : 1'b0;
      assign nbr[3] = LF_OK            ? grid_q[r*WIDTH + CL]  : 1'b0;
      assign nbr[4] = RT_OK            ? grid_q[r*WIDTH + CR]  : 1'b0;
      assign nbr[5] = (DN_OK && LF_OK) ? grid_q[RD*WIDTH + CL] : 1'b0;
      assign nbr[6] = DN_OK            ? grid_q[RD*WIDTH + c]  : 1'b0;
      assign nbr[7] = (DN_OK && RT_OK) ? grid_q[RD*WIDTH + CR] : 1'b0;

      silife_cell u_cell (
        .clk        (clk),
        .reset      (reset),
        .enable     (step_en),
        .write_en   (row_hit[r]),
        .set_bit    (set_cells[c]),
        .clear_bit  (clear_cells[c]),
        .neighbours (nbr),
        .alive      (grid_q[r*WIDTH + c]),
        .next_alive (next_grid[r*WIDTH + c])
      );
    end
  end

  // Read mux; addresses past the last row fall through to zero.
  always_comb begin
    cells = '0;
    for (int r = 0; r < HEIGHT; r++) begin
      if (32'(row_select) == r) cells = grid_q[r*WIDTH +: WIDTH];
    end
  end

  // Extinct tracks the registered grid directly, so it follows writes, steps and reset alike.
  assign extinct = ~|grid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      gen_count <= '0;
      stable    <= 1'b0;
    end else if (step_en) begin
      if (gen_count != '1) gen_count <= gen_count + 1'b1;
      stable <= (next_grid == grid_q);
    end
  end

endmodule

// File: tb/tb_silife_grid.sv
// Purpose: directed self-checking bench for silife_grid (8x8, plus a GEN_BITS=4 copy).
// Latency: n/a.
// Backpressure: n/a.
module tb_silife_grid;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [2:0] row_select;
  logic [7:0] set_cells;
  logic [7:0] clear_cells;
  logic       write_en;

  logic [7:0]  cells;
  logic [15:0] gen_count;
  logic        stable;
  logic        extinct;

  logic [7:0] cells4;
  logic [3:0] gen_count4;
  logic       stable4;
  logic       extinct4;

  int tests_run    = 0;
  int tests_failed = 0;

  silife_grid dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .row_select  (row_select),
    .set_cells   (set_cells),
    .clear_cells (clear_cells),
    .write_en    (write_en),
    .cells       (cells),
    .gen_count   (gen_count),
    .stable      (stable),
    .extinct     (extinct)
  );

  silife_grid #(.GEN_BITS(4)) dut_g4 (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .row_select  (row_select),
    .set_cells   (set_cells),
    .clear_cells (clear_cells),
    .write_en    (write_en),
    .cells       (cells4),
    .gen_count   (gen_count4),
    .stable      (stable4),
    .extinct     (extinct4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic write_row(input logic [2:0] r, input logic [7:0] s, input logic [7:0] c);
    write_en    = 1'b1;
    row_select  = r;
    set_cells   = s;
    clear_cells = c;
    tick();
    write_en    = 1'b0;
    set_cells   = '0;
    clear_cells = '0;
  endtask

  task automatic step(input int n);
    enable = 1'b1;
    repeat (n) tick();
    enable = 1'b0;
  endtask

  task automatic read_row(input logic [2:0] r, output logic [7:0] v);
    row_select = r;
    #1;
    v = cells;
  endtask

  // exp holds row 7 in the top byte down to row 0 in the bottom byte.
  task automatic check_grid(input string tag, input logic [63:0] exp);
    logic [7:0] v;
    for (int r = 0; r < 8; r++) begin
      read_row(3'(r), v);
      check($sformatf("%s row%0d", tag, r), 32'(v), 32'(exp[r*8 +: 8]));
    end
  endtask

  initial begin
    logic [7:0] v;
    int         pop;

    reset       = 1'b0;
    enable      = 1'b0;
    write_en    = 1'b0;
    row_select  = '0;
    set_cells   = '0;
    clear_cells = '0;

    // Reset state
    do_reset();
    check("rst gen", 32'(gen_count), 0);
    check("rst stable", 32'(stable), 0);
    check("rst extinct", 32'(extinct), 1);
    check_grid("rst", 64'h0);

    // Blinker
    write_row(3'd4, 8'h70, 8'h00);
    check("blk wr extinct", 32'(extinct), 0);
    check("blk wr gen", 32'(gen_count), 0);
    step(1);
    check_grid("blk s1", 64'h00002020_20000000);
    check("blk s1 gen", 32'(gen_count), 1);
    step(1);
    check_grid("blk s2", 64'h00000070_00000000);
    check("blk s2 gen", 32'(gen_count), 2);
    check("blk s2 stable", 32'(stable), 0);

    // Still-life block
    do_reset();
    write_row(3'd2, 8'h0C, 8'h00);
    write_row(3'd3, 8'h0C, 8'h00);
    step(1);
    check_grid("block", 64'h00000000_0C0C0000);
    check("block stable", 32'(stable), 1);
    check("block extinct", 32'(extinct), 0);
    check("block gen", 32'(gen_count), 1);

    // Lone cell dies, then extinct grid keeps stepping
    do_reset();
    write_row(3'd0, 8'h01, 8'h00);
    step(1);
    check_grid("single", 64'h0);
    check("single extinct", 32'(extinct), 1);
    check("single stable", 32'(stable), 0);
    step(2);
    check("ext extinct", 32'(extinct), 1);
    check("ext stable", 32'(stable), 1);
    check("ext gen", 32'(gen_count), 3);

    // Write and step requested together: write wins, no step
    enable      = 1'b1;
    write_en    = 1'b1;
    row_select  = 3'd5;
    set_cells   = 8'h80;
    clear_cells = 8'h00;
    tick();
    enable   = 1'b0;
    write_en = 1'b0;
    read_row(3'd5, v);
    check("coll row5", 32'(v), 32'h80);
    check("coll gen", 32'(gen_count), 3);
    check("coll extinct", 32'(extinct), 0);
    check("coll stable", 32'(stable), 1);
    enable      = 1'b1;
    write_en    = 1'b1;
    row_select  = 3'd5;
    set_cells   = 8'hFF;
    clear_cells = 8'hFF;
    tick();
    enable      = 1'b0;
    write_en    = 1'b0;
    set_cells   = '0;
    clear_cells = '0;
    read_row(3'd5, v);
    check("clrwin row5", 32'(v), 32'h00);
    check("clrwin gen", 32'(gen_count), 3);
    check("clrwin extinct", 32'(extinct), 1);

    // Glider heading down-right
    do_reset();
    write_row(3'd0, 8'h02, 8'h00);
    write_row(3'd1, 8'h04, 8'h00);
    write_row(3'd2, 8'h07, 8'h00);
    step(32);
    check("glider gen", 32'(gen_count), 32);
    check("glider extinct", 32'(extinct), 0);
`ifdef SILIFE_WRAP_EN
    check_grid("glider wrap", 64'h00000000_00070402);
    pop = 0;
    for (int r = 0; r < 8; r++) begin
      read_row(3'(r), v);
      pop += $countones(v);
    end
    check("glider pop", 32'(pop), 5);
    check("glider stable", 32'(stable), 0);
`else
    check_grid("glider edge", 64'hC0C00000_00000000);
    check("glider stable", 32'(stable), 1);
`endif

    // Reset overrides a concurrent write and step
    do_reset();
    write_row(3'd4, 8'h70, 8'h00);
    step(3);
    reset       = 1'b1;
    enable      = 1'b1;
    write_en    = 1'b1;
    row_select  = 3'd0;
    set_cells   = 8'hFF;
    tick();
    reset       = 1'b0;
    enable      = 1'b0;
    write_en    = 1'b0;
    set_cells   = '0;
    check_grid("midrst", 64'h0);
    check("midrst gen", 32'(gen_count), 0);
    check("midrst extinct", 32'(extinct), 1);
    check("midrst stable", 32'(stable), 0);

    // Saturation of a 4-bit counter alongside the 16-bit one
    write_row(3'd4, 8'h70, 8'h00);
    step(20);
    check("sat gen4", 32'(gen_count4), 15);
    check("sat gen16", 32'(gen_count), 20);
    row_select = 3'd4;
    #1;
    check("sat g4 row4", 32'(cells4), 32'h70);
    check("sat g4 extinct", 32'(extinct4), 0);
    check("sat g4 stable", 32'(stable4), 0);

    // Idle holds everything
    repeat (3) tick();
    check("idle gen", 32'(gen_count), 20);
    read_row(3'd4, v);
    check("idle row4", 32'(v), 32'h70);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
